// File: rtl/timer_core_if.sv
// Bus bundle for timer_core: load/start controls, raw pause button and timer status outputs.
interface timer_core_if #(
    parameter int TW = 17
);
    logic          load;
    logic [TW-1:0] start_time;
    logic          mode;
    logic          pause_n;
    logic [TW-1:0] value;
    logic          running;
    logic          done;
    logic          blink;

    modport master (
        output load, start_time, mode, pause_n,
        input  value, running, done, blink
    );

    modport slave (
        input  load, start_time, mode, pause_n,
        output value, running, done, blink
    );
endinterface

// File: rtl/timer_core.sv
// Count-down/count-up timer with a tick divider, a synchronised pause button and a blinking sticky done flag.
// Optional macro AUTO_RELOAD_EN: a terminal tick reloads the start value and pulses done instead of stopping.
module timer_core #(
    parameter int TW           = 17,
    parameter int TICK_CYCLES  = 50000000,
    parameter int BLINK_CYCLES = 25000000,
    parameter int DIV_W        = 32
) (
    input logic         clk,
    input logic         rst,
    timer_core_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [DIV_W-1:0] TICK_LAST  = DIV_W'(TICK_CYCLES - 1);
    localparam logic [DIV_W-1:0] BLINK_LAST = DIV_W'(BLINK_CYCLES - 1);

    state_t           state_q, state_d;
    logic [TW-1:0]    value_q, value_d;
    logic [TW-1:0]    target_q, target_d;
    logic [TW-1:0]    step_val;
    logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [DIV_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             blink_q, blink_d;
    logic             running_q, running_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             hist_q, hist_d;
    logic             press, tick, terminal;

    // A press is a falling edge seen after two synchroniser stages.
    assign sync1_d  = bus.pause_n;
    assign sync2_d  = sync1_q;
    assign hist_d   = sync2_q;
    assign press    = hist_q & ~sync2_q;
    assign tick     = (state_q == RUN) && (tick_cnt_q == TICK_LAST);
    assign step_val = mode_q ? value_q + TW'(1) : value_q - TW'(1);
    assign terminal = mode_q ? (step_val == target_q) : (step_val == '0);

    always_comb begin
        state_d     = state_q;
        value_d     = value_q;
        target_d    = target_q;
        mode_d      = mode_q;
        tick_cnt_d  = tick_cnt_q;
        blink_cnt_d = blink_cnt_q;
        done_d      = done_q;
        blink_d     = blink_q;
`ifdef AUTO_RELOAD_EN
        done_d      = 1'b0;
`endif
        if (bus.load) begin
            tick_cnt_d  = '0;
            blink_cnt_d = '0;
            done_d      = 1'b0;
            blink_d     = 1'b0;
            if (bus.start_time == '0) begin
                state_d = IDLE;
                value_d = '0;
            end else begin
                state_d  = RUN;
                value_d  = bus.mode ? '0 : bus.start_time;
                target_d = bus.start_time;
                mode_d   = bus.mode;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (tick) begin
                        tick_cnt_d = '0;
                        if (terminal) begin
`ifdef AUTO_RELOAD_EN
                            value_d = mode_q ? '0 : target_q;
                            done_d  = 1'b1;
                            if (press) state_d = PAUSE;
`else
                            // Terminal tick wins over a simultaneous press.
                            value_d = step_val;
                            state_d = DONE;
                            done_d  = 1'b1;
`endif
                        end else begin
                            value_d = step_val;
                            if (press) state_d = PAUSE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + DIV_W'(1);
                        if (press) state_d = PAUSE;
                    end
                end
                PAUSE: begin
                    if (press) state_d = RUN;
                end
                DONE: begin
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        blink_d     = ~blink_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + DIV_W'(1);
                    end
                    if (press) begin
                        state_d     = IDLE;
                        done_d      = 1'b0;
                        blink_d     = 1'b0;
                        blink_cnt_d = '0;
                    end
                end
                default: ;
            endcase
        end
        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            value_q     <= '0;
            target_q    <= '0;
            mode_q      <= 1'b0;
            tick_cnt_q  <= '0;
            blink_cnt_q <= '0;
            done_q      <= 1'b0;
            blink_q     <= 1'b0;
            running_q   <= 1'b0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            hist_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            value_q     <= value_d;
            target_q    <= target_d;
            mode_q      <= mode_d;
            tick_cnt_q  <= tick_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            done_q      <= done_d;
            blink_q     <= blink_d;
            running_q   <= running_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            hist_q      <= hist_d;
        end
    end

    assign bus.value   = value_q;
    assign bus.running = running_q;
    assign bus.done    = done_q;
    assign bus.blink   = blink_q;
endmodule

// File: tb/tb_timer_core.sv
// Bench for timer_core: vector table, directed corner sequences and random traffic against a reference model.
module tb_timer_core;
    localparam int TW    = 8;
    localparam int TICK  = 4;
    localparam int BLINK = 2;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
`ifdef AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    timer_core_if #(.TW(TW)) bus();

    timer_core #(
        .TW(TW), .TICK_CYCLES(TICK), .BLINK_CYCLES(BLINK), .DIV_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: value is derived from elapsed whole ticks, blink from time spent in DONE.
    int m_st, m_mode, m_target, m_elapsed, m_phase, m_dcount;
    bit m_pulse;
    bit pn_hist[$];

    typedef struct {
        bit ld; int st; bit md; bit pn; int cyc;
        int v; bit r; bit d; bit b;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int m_value();
        return m_mode != 0 ? m_elapsed : m_target - m_elapsed;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_mode = 0; m_target = 0; m_elapsed = 0;
        m_phase = 0; m_dcount = 0; m_pulse = 1'b0;
        pn_hist = '{1'b1, 1'b1, 1'b1};
    endtask

    task automatic model_step(input bit ld, input int st, input bit md, input bit pn);
        bit press;
        press = pn_hist[0] && !pn_hist[1];
        pn_hist.push_back(pn);
        void'(pn_hist.pop_front());
        m_pulse = 1'b0;
        if (ld) begin
            m_phase = 0; m_dcount = 0;
            if (st == 0) begin
                m_st = M_IDLE; m_mode = 0; m_target = 0; m_elapsed = 0;
            end else begin
                m_st = M_RUN; m_mode = md; m_target = st; m_elapsed = 0;
            end
        end else if (m_st == M_RUN) begin
            m_phase++;
            if (m_phase == TICK) begin
                m_phase = 0;
                m_elapsed++;
                if (m_elapsed == m_target) begin
                    if (AUTO) begin
                        m_elapsed = 0;
                        m_pulse = 1'b1;
                        if (press) m_st = M_PAUSE;
                    end else begin
                        m_st = M_DONE;
                        m_dcount = 0;
                    end
                end else if (press) m_st = M_PAUSE;
            end else if (press) m_st = M_PAUSE;
        end else if (m_st == M_PAUSE) begin
            if (press) m_st = M_RUN;
        end else if (m_st == M_DONE) begin
            m_dcount++;
            if (press) begin
                m_st = M_IDLE; m_dcount = 0;
            end
        end
    endtask

    task automatic compare_model();
        chk("model.value", int'(bus.value), m_value());
        chk("model.running", int'(bus.running), int'(m_st == M_RUN));
        chk("model.done", int'(bus.done), AUTO ? int'(m_pulse) : int'(m_st == M_DONE));
        chk("model.blink", int'(bus.blink), (m_st == M_DONE) ? (m_dcount / BLINK) % 2 : 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_step(bus.load, int'(bus.start_time), bus.mode, bus.pause_n);
        #1;
        compare_model();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.load = 1'b0; bus.start_time = '0; bus.mode = 1'b0; bus.pause_n = 1'b1;
        model_reset();
        #12;
        chk("rst.value", int'(bus.value), 0);
        chk("rst.running", int'(bus.running), 0);
        chk("rst.done", int'(bus.done), 0);
        chk("rst.blink", int'(bus.blink), 0);
        @(negedge clk) rst = 1'b1;

        // Asynchronous reset in the middle of a count.
        bus.start_time = 5; bus.mode = 1'b0; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        repeat (6) step();
        #2 rst = 1'b0;
        #1;
        chk("async.value", int'(bus.value), 0);
        chk("async.running", int'(bus.running), 0);
        chk("async.done", int'(bus.done), 0);
        chk("async.blink", int'(bus.blink), 0);
        model_reset();
        @(negedge clk) rst = 1'b1;

        // Vector table: count-down run, blink, acknowledge and ignored press in IDLE.
`ifdef AUTO_RELOAD_EN
        tbl.push_back('{1, 2, 0, 1, 1, 2, 1, 0, 0});
        tbl.push_back('{0, 2, 0, 1, 3, 2, 1, 0, 0});
        tbl.push_back('{0, 2, 0, 1, 1, 1, 1, 0, 0});
        tbl.push_back('{0, 2, 0, 1, 3, 1, 1, 0, 0});
        tbl.push_back('{0, 2, 0, 1, 1, 2, 1, 1, 0});
        tbl.push_back('{0, 2, 0, 1, 1, 2, 1, 0, 0});
        tbl.push_back('{0, 2, 0, 1, 2, 2, 1, 0, 0});
        tbl.push_back('{0, 2, 0, 1, 1, 1, 1, 0, 0});
        tbl.push_back('{0, 2, 0, 1, 4, 2, 1, 1, 0});
        tbl.push_back('{0, 2, 0, 1, 1, 2, 1, 0, 0});
`else
        tbl.push_back('{1, 3, 0, 1, 1, 3, 1, 0, 0});
        tbl.push_back('{0, 3, 0, 1, 3, 3, 1, 0, 0});
        tbl.push_back('{0, 3, 0, 1, 1, 2, 1, 0, 0});
        tbl.push_back('{0, 3, 0, 1, 4, 1, 1, 0, 0});
        tbl.push_back('{0, 3, 0, 1, 3, 1, 1, 0, 0});
        tbl.push_back('{0, 3, 0, 1, 1, 0, 0, 1, 0});
        tbl.push_back('{0, 3, 0, 1, 1, 0, 0, 1, 0});
        tbl.push_back('{0, 3, 0, 1, 1, 0, 0, 1, 1});
        tbl.push_back('{0, 3, 0, 1, 2, 0, 0, 1, 0});
        tbl.push_back('{0, 3, 0, 0, 3, 0, 0, 0, 0});
        tbl.push_back('{0, 3, 0, 1, 5, 0, 0, 0, 0});
        tbl.push_back('{0, 3, 0, 0, 5, 0, 0, 0, 0});
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            bus.load = tbl[i].ld; bus.start_time = TW'(tbl[i].st);
            bus.mode = tbl[i].md; bus.pause_n = tbl[i].pn;
            for (int c = 0; c < tbl[i].cyc; c++) begin
                step();
                bus.load = 1'b0;
            end
            chk($sformatf("vec%0d.value", i), int'(bus.value), tbl[i].v);
            chk($sformatf("vec%0d.running", i), int'(bus.running), int'(tbl[i].r));
            chk($sformatf("vec%0d.done", i), int'(bus.done), int'(tbl[i].d));
            chk($sformatf("vec%0d.blink", i), int'(bus.blink), int'(tbl[i].b));
        end

        // Count up with a held pause button, then resume with the saved tick phase.
        bus.pause_n = 1'b1; bus.mode = 1'b1; bus.start_time = 4; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        repeat (8) step();
        chk("up.at2", int'(bus.value), 2);
        bus.pause_n = 1'b0;
        repeat (10) step();
        chk("pause.value", int'(bus.value), 2);
        chk("pause.running", int'(bus.running), 0);
        bus.pause_n = 1'b1;
        repeat (4) step();
        chk("pause.hold", int'(bus.value), 2);
        bus.pause_n = 1'b0;
        repeat (3) step();
        chk("resume.running", int'(bus.running), 1);
        for (int k = 0; k < 64 && !bus.done; k++) step();
        chk("up.done_seen", int'(bus.done), 1);
        chk("up.done_value", int'(bus.value), AUTO ? 0 : 4);
        bus.pause_n = 1'b1;
        repeat (4) step();

        // Zero load goes idle; load beats a coincident tick and press.
        bus.mode = 1'b0; bus.start_time = 0; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        chk("zero.value", int'(bus.value), 0);
        chk("zero.running", int'(bus.running), 0);
        chk("zero.done", int'(bus.done), 0);
        bus.start_time = 5; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        repeat (5) step();
        bus.pause_n = 1'b0;
        repeat (2) step();
        bus.start_time = 2; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        chk("prio.value", int'(bus.value), 2);
        chk("prio.running", int'(bus.running), 1);
        bus.start_time = 7;
        repeat (3) step();
        chk("prio.still_running", int'(bus.running), 1);
        chk("prio.ignored_start", int'(bus.value), 2);
        bus.pause_n = 1'b1;
        repeat (3) step();

        // Random loads, start_time churn and button activity.
        for (int i = 0; i < 3000; i++) begin
            bus.load = ($urandom_range(0, 39) == 0);
            bus.start_time = TW'($urandom_range(0, 9));
            bus.mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) bus.pause_n = ~bus.pause_n;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/timer_core.md
Name: timer_core

Overview:
Parametrised second-generation countdown/count-up timer for the clock application. Loads a start time, counts in whole-tick units derived from a cycle divider, and supports pause/resume from a raw push-button. Raises a sticky done flag with a blink signal for display flashing. Sits between the time-entry logic and the display formatter; the value output feeds the hh:mm:ss splitter.

Parameters:
TW, 17, width of start_time and value (seconds).
TICK_CYCLES, 50000000, clk cycles per count tick (1 s at 50 MHz); must be >= 2.
BLINK_CYCLES, 25000000, clk cycles per blink half-period; must be >= 1.
DIV_W, 32, width of the tick and blink cycle counters.

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst  in  1  asynchronous, active-low reset.
load  in  1  synchronous pulse; captures start_time and arms the timer.
start_time  in  TW  target time in seconds.
mode  in  1  0 = count down from start_time to 0; 1 = count up from 0 to start_time. Sampled only on load.
pause_n  in  1  raw active-low button, asynchronous to clk.
value  out  TW  current timer value.
running  out  1  high in RUN.
done  out  1  high in DONE (sticky, unless AUTO_RELOAD_EN is defined).
blink  out  1  toggles every BLINK_CYCLES while done; 0 otherwise.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; value=0, running=0, done=0, blink=0; tick and blink counters 0; pause synchroniser flops 1 (released); stored mode 0, stored target 0.
- pause_n passes through a 2-flop synchroniser plus one history flop. A press is a falling edge of the synchronised signal. The press acts on the 3rd rising edge after pause_n is first sampled low. A held button produces exactly one press; there is no debounce.
- States: IDLE, RUN, PAUSE, DONE.
- load, from any state, has priority over a press and a tick in the same cycle:
  - Tick counter cleared; done and blink cleared.
  - If start_time=0: state IDLE, value=0.
  - Otherwise: state RUN; value = start_time (down) or 0 (up); start_time and mode latched internally. Later start_time changes are ignored until the next load.
- RUN: tick counter increments each cycle. At TICK_CYCLES-1 it wraps to 0 and value steps by 1 (decrements when down, increments when up).
  - On the step that reaches the terminal value (0 for down, target for up): state DONE, done=1 on the same edge. No wrap past the terminal value.
  - A press moves to PAUSE.
  - If a press and a tick occur in the same cycle: the tick is applied, then the state goes to PAUSE. The exception is a terminal tick, which goes to DONE and the press is discarded.
- PAUSE: value and tick counter held; the fractional tick is preserved. A press returns to RUN.
- DONE: value held at the terminal value. The blink counter runs, and blink toggles when it reaches BLINK_CYCLES-1, starting from 0. A press acknowledges: state IDLE, done=0, blink=0, value retained.
- IDLE: presses ignored; value held.
- running = (state==RUN), registered with the state.
- All counters are unsigned modulo their widths. TW arithmetic never overflows, because the terminal-value checks prevent stepping beyond 0 or the target.

Optional Feature:
AUTO_RELOAD_EN
- Defined: a terminal tick in RUN does not enter DONE. value reloads to the initial value (start_time for down, 0 for up) on the same edge, and the state stays RUN. done pulses high for exactly one cycle; blink stays 0. A press still pauses.
- Undefined: sticky DONE behaviour as above.

Test Plan:
Test parameters: TICK_CYCLES=4, BLINK_CYCLES=2, TW=8.
1. Reset mid-RUN: load start_time=5 in down mode, run 6 cycles, pulse rst low → value=0, running=0, done=0, blink=0 immediately, without waiting for a clk edge.
2. Count down: load start_time=3, mode=0 → value reads 3,2,1,0 at 4-cycle intervals; done=1 on the edge value becomes 0; blink toggles every 2 cycles afterwards; value stays 0.
3. Count up with pause: load start_time=4, mode=1; press pause_n low for 10 cycles after value=2 → value frozen at 2 while paused. Release, press again → counting resumes with the remaining tick phase; done when value=4.
4. Zero and load priority: load start_time=0 → IDLE, value=0, done=0. Then load start_time=2 in the same cycle as a tick and a press → value=2, RUN, no pause.
5. Acknowledge: in DONE, press → IDLE, done=0, blink=0, value unchanged. A further press leaves the state IDLE.
6. With AUTO_RELOAD_EN: load start_time=2, mode=0 → value 2,1,2,1…; done is a 1-cycle pulse each time the reload happens; running stays 1.
